ram_rd_stream: RTL and testbench

Read-side sequencer for the shared single-port score RAM, and the counterpart to the RAM write controller. On a `start` pulse it reads `length` consecutive words beginning at `base_addr` from the synchronous RAM (one-cycle read latency) and streams them out on a valid/ready interface with `out_last` on the final word. It feeds downstream consumers such as result dump and traceback logic. It never writes the RAM.

---
 rtl/ram_rd_stream_if.sv | 29 ++
 rtl/ram_rd_stream.sv | 121 ++++++++++++
 tb/tb_ram_rd_stream.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ram_rd_stream_if.sv
// Bundle of the read sequencer's control, RAM read port and output stream signals.
// The master modport is the sequencer. The slave modport is the RAM model plus the consumer.
interface ram_rd_stream_if #(
  parameter int unsigned ADDR_LEN = 16,
  parameter int unsigned DATA_LEN = 8
);
  logic                start;
  logic [ADDR_LEN-1:0] base_addr;
  logic [ADDR_LEN:0]   length;
  logic [DATA_LEN-1:0] rd_data;
  logic                out_ready;
  logic                rd_en;
  logic [ADDR_LEN-1:0] rd_addr;
  logic [DATA_LEN-1:0] out_data;
  logic                out_valid;
  logic                out_last;
  logic                busy;
  logic                done;

  modport master (
    input  start, base_addr, length, rd_data, out_ready,
    output rd_en, rd_addr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, base_addr, length, rd_data, out_ready,
    input  rd_en, rd_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/ram_rd_stream.sv
// Streams `length` consecutive words out of a synchronous single-port RAM onto a valid/ready
// interface. Reads are throttled so that the 2-entry output FIFO can never overflow.
module ram_rd_stream #(
  parameter int unsigned ADDR_LEN = 16,
  parameter int unsigned DATA_LEN = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  ram_rd_stream_if.master      bus
);
  localparam int unsigned CntW = ADDR_LEN + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [CntW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]     out_cnt_q, out_cnt_d;
  logic                done_q, done_d;
  logic                inflight_q;
  logic [DATA_LEN-1:0] mem_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q;

  logic       pop;
  logic       rd_en;
  logic [2:0] occ;

  assign pop = (count_q != 2'd0) && bus.out_ready;
  // Occupancy the FIFO will have once the word in flight lands and this cycle's pop retires.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en = (state_q == StRead) && (issue_cnt_q != '0) && (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    done_d      = 1'b0;
    if (pop) begin
      out_cnt_d = out_cnt_q - CntW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            state_d     = StRead;
            addr_d      = bus.base_addr;
            issue_cnt_d = bus.length;
            out_cnt_d   = bus.length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (rd_en) begin
          addr_d      = addr_q + ADDR_LEN'(1);
          issue_cnt_d = issue_cnt_q - CntW'(1);
          if (issue_cnt_q == CntW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && (out_cnt_q == CntW'(1))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
    end
  end

  // RAM data arrives one cycle after the strobe; inflight marks that cycle as a FIFO push.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= rd_en;
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= bus.rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = addr_q;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_last  = (count_q != 2'd0) && (out_cnt_q == CntW'(1));
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed bench for ram_rd_stream: a table of transfers with ready patterns, plus sequences
// for reset mid-transfer, start while busy and start in the done cycle.
module tb_ram_rd_stream;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  ram_rd_stream_if #(.ADDR_LEN(16), .DATA_LEN(8)) bus ();

  ram_rd_stream #(.ADDR_LEN(16), .DATA_LEN(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // RAM model: RAM[a] = a[7:0], one-cycle read latency.
  always @(posedge CLK) begin
    if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] base;
    logic [16:0] len;
    logic [15:0] pat;       // out_ready in cycle c is pat[c % 16]
    int          exp_done;  // cycle of the done pulse after start edge; 0 = not checked
  } vec_t;

  vec_t vecs[7];
  logic [15:0] chain_base;
  logic [16:0] chain_len;
  int hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input logic [15:0] base, input logic [16:0] len, input logic [15:0] pat,
                          input int exp_done, input int inj_cyc, input bit chain,
                          input bit skip_start);
    int rd_cnt = 0;
    int got = 0;
    int done_cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic pl = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [15:0] ea;
    logic [15:0] ew;
    if (!skip_start) begin
      @(negedge CLK);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.length    = len;
    end
    @(posedge CLK);
    for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
      @(negedge CLK);
      bus.start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        bus.base_addr = 16'h0099;
        bus.length    = 17'd3;
      end
      bus.out_ready = pat[cyc % 16];
      #1;
      if (bus.rd_en) begin
        ea = base + 16'(rd_cnt);
        chk("rd_addr", 32'(bus.rd_addr), 32'(ea));
        rd_cnt++;
      end
      if (pv && !pr) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(bus.out_data), 32'(pd));
        chk("stall_last", 32'(bus.out_last), 32'(pl));
      end
      if (bus.out_valid) begin
        ew = base + 16'(got);
        chk("out_data", 32'(bus.out_data), 32'(ew[7:0]));
        chk("out_last", 32'(bus.out_last), 32'(got == int'(len) - 1));
        if (bus.out_ready) got++;
      end
      chk("outstanding", 32'(rd_cnt - got <= 2), 32'd1);
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
      if (bus.done) begin
        done_cyc = cyc;
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        if (chain) begin
          bus.start     = 1'b1;
          bus.base_addr = chain_base;
          bus.length    = chain_len;
        end
      end else begin
        chk("busy", 32'(bus.busy), 32'(len != 17'd0));
      end
    end
    chk("done_seen", 32'(done_cyc != 0), 32'd1);
    if (exp_done != 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("word_count", 32'(got), 32'(len));
    chk("rd_count", 32'(rd_cnt), 32'(len));
    if (!chain) begin
      @(negedge CLK);
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("done_width", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{base: 16'h0010, len: 17'd4, pat: 16'hFFFF, exp_done: 7};
    vecs[1] = '{base: 16'h0010, len: 17'd4, pat: 16'h3333, exp_done: 10};
    vecs[2] = '{base: 16'h0000, len: 17'd0, pat: 16'hFFFF, exp_done: 1};
    vecs[3] = '{base: 16'hFFFE, len: 17'd4, pat: 16'hFFFF, exp_done: 7};
    vecs[4] = '{base: 16'h0040, len: 17'd3, pat: 16'hFFC1, exp_done: 9};
    vecs[5] = '{base: 16'hFFFF, len: 17'd1, pat: 16'hFFFF, exp_done: 4};
    vecs[6] = '{base: 16'h0123, len: 17'd9, pat: 16'($urandom) | 16'h8421, exp_done: 0};

    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.out_ready = 1'b0;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    RST = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_xfer(vecs[i].base, vecs[i].len, vecs[i].pat, vecs[i].exp_done, 0, 1'b0, 1'b0);
    end

    // Reset after three handshakes of an 8-word transfer.
    @(negedge CLK);
    bus.start     = 1'b1;
    bus.base_addr = 16'h0030;
    bus.length    = 17'd8;
    bus.out_ready = 1'b1;
    @(posedge CLK);
    hs = 0;
    for (int c = 1; c <= 20 && hs < 3; c++) begin
      @(negedge CLK);
      bus.start = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk("pre_rst_data", 32'(bus.out_data), 32'h30 + 32'(hs));
        hs++;
      end
    end
    chk("pre_rst_handshakes", 32'(hs), 32'd3);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    chk("midrst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("midrst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_last", 32'(bus.out_last), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("postrst_done", 32'(bus.done), 32'd0);
    chk("postrst_valid", 32'(bus.out_valid), 32'd0);
    run_xfer(16'h0020, 17'd2, 16'hFFFF, 5, 0, 1'b0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    chain_base = 16'h0060;
    chain_len  = 17'd2;
    run_xfer(16'h0050, 17'd6, 16'hFFFF, 9, 2, 1'b1, 1'b0);
    run_xfer(16'h0060, 17'd2, 16'hFFFF, 5, 0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
